// File: rtl/uart_cmd_regfile_pkg.sv
// Shared definitions for the UART command decoder: opcodes, readback
// indices, command word fields and the opcode classifier.
package uart_cmd_regfile_pkg;

  localparam int CMD_W  = 20;
  localparam int OP_W   = 8;
  localparam int PL_W   = 12;
  localparam int OP_LSB = 12;

  localparam logic [7:0] OP_SEG     = 8'hF0;
  localparam logic [7:0] OP_RATE    = 8'hF1;
  localparam logic [7:0] OP_REFRESH = 8'hF2;
  localparam logic [7:0] OP_WAV     = 8'hF3;
  localparam logic [7:0] OP_SRST    = 8'hF4;
  localparam logic [7:0] OP_READ    = 8'hF5;
  localparam logic [7:0] OP_COMMIT  = 8'hF6;
  localparam logic [3:0] OP_FREQ_HI = 4'hD;

  localparam logic [7:0] RB_SEG     = 8'h00;
  localparam logic [7:0] RB_RATE    = 8'h01;
  localparam logic [7:0] RB_ERR     = 8'h02;
  localparam logic [3:0] RB_WAV_HI  = 4'h1;
  localparam logic [3:0] RB_FREQ_HI = 4'h2;

  localparam logic [2:0] SEG_MAX  = 3'd4;
  localparam logic [2:0] SEG_DEF  = 3'd0;
  localparam logic [1:0] RATE_DEF = 2'd2;
  localparam logic [7:0] ERR_SAT  = 8'hFF;

  typedef enum logic [3:0] {
    K_NONE,
    K_SEG,
    K_RATE,
    K_REFRESH,
    K_WAV,
    K_SRST,
    K_READ,
    K_COMMIT,
    K_FREQ
  } cmd_kind_t;

  // Classify an opcode; channel range checks are left to the caller.
  function automatic cmd_kind_t op_kind(input logic [7:0] op);
    cmd_kind_t k;
    k = K_NONE;
    case (op)
      OP_SEG:     k = K_SEG;
      OP_RATE:    k = K_RATE;
      OP_REFRESH: k = K_REFRESH;
      OP_WAV:     k = K_WAV;
      OP_SRST:    k = K_SRST;
      OP_READ:    k = K_READ;
      OP_COMMIT:  k = K_COMMIT;
      default:    k = (op[7:4] == OP_FREQ_HI) ? K_FREQ : K_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/uart_cmd_regfile_if.sv
// Command/response channel between the UART deframer and the decoder.
interface uart_cmd_regfile_if;
  import uart_cmd_regfile_pkg::*;

  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_data;
  logic             cmd_ack;
  logic             cmd_err;
  logic             resp_valid;
  logic [PL_W-1:0]  resp_data;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ack, cmd_err, resp_valid, resp_data
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ack, cmd_err, resp_valid, resp_data
  );
endinterface

// File: rtl/uart_cmd_pulse.sv
// Retriggerable fixed-length pulse: active for LEN cycles after the last
// trigger. POLARITY selects the active level of the output.
module uart_cmd_pulse #(
  parameter int LEN      = 2,
  parameter bit POLARITY = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  input  logic clr,
  output logic pulse
);

  localparam int CW = $clog2(LEN);

  logic [CW-1:0] remain;

  // Down-counter with terminal-count compare; a trigger always reloads,
  // so a retrigger on the terminal cycle extends the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse  <= ~POLARITY;
      remain <= '0;
    end else if (trig) begin
      pulse  <= POLARITY;
      remain <= CW'(LEN - 1);
    end else if (clr) begin
      pulse  <= ~POLARITY;
      remain <= '0;
    end else if (pulse == POLARITY) begin
      if (remain == '0) pulse <= ~POLARITY;
      else remain <= remain - CW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_regfile.sv
// UART command decoder and control register file: decodes framed command
// words into display, FFT and per-channel DDS controls, with optional
// shadow/commit staging, readback, soft reset and error counting.
module uart_cmd_regfile
  import uart_cmd_regfile_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int FREQ_W    = 12,
  parameter int FREQ_DEF  = 500,
  parameter int PULSE_LEN = 20000,
  parameter int RST_LEN   = 64,
  parameter int SHADOW    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_cmd_regfile_if.slave        bus,
  output logic                     refresh,
  output logic                     system_resetn,
  output logic [2:0]               seg_en,
  output logic [1:0]               fft_rate,
  output logic [2*NUM_CH-1:0]      wav_sel,
  output logic [FREQ_W*NUM_CH-1:0] freq,
  output logic [7:0]               err_cnt
);

  localparam logic [FREQ_W-1:0] FREQ_RST = FREQ_W'(FREQ_DEF);

  logic [OP_W-1:0] op;
  logic [PL_W-1:0] pl;
  cmd_kind_t       kind;
  logic            legal;
  logic            accept;
  logic            reject;
  logic [PL_W-1:0] rb_val;
  logic            do_srst;
  logic            do_refresh;
  logic            srst_busy;

  logic [2:0]        seg_sh;
  logic [1:0]        rate_sh;
  logic [1:0]        wav_sh   [NUM_CH];
  logic [FREQ_W-1:0] freq_sh  [NUM_CH];
  logic [1:0]        wav_act  [NUM_CH];
  logic [FREQ_W-1:0] freq_act [NUM_CH];

  assign op         = bus.cmd_data[CMD_W-1:OP_LSB];
  assign pl         = bus.cmd_data[PL_W-1:0];
  assign srst_busy  = ~system_resetn;
  assign do_srst    = accept && (kind == K_SRST);
  assign do_refresh = accept && (kind == K_REFRESH);

  function automatic logic ch_ok(input logic [3:0] ch);
    return {28'd0, ch} < 32'(NUM_CH);
  endfunction

  // Decode the command word, validate its payload and pick the readback value.
  always_comb begin
    kind   = op_kind(op);
    legal  = 1'b0;
    rb_val = '0;
    case (kind)
      K_SEG:     legal = (pl[2:0] <= SEG_MAX);
      K_RATE:    legal = (pl[11:2] == '0);
      K_REFRESH: legal = 1'b1;
      K_SRST:    legal = 1'b1;
      K_COMMIT:  legal = 1'b1;
      K_WAV:     legal = ch_ok(pl[11:8]);
      K_FREQ:    legal = ch_ok(op[3:0]);
      K_READ: begin
        if (pl[7:0] == RB_SEG) begin
          legal  = 1'b1;
          rb_val = {9'd0, seg_en};
        end else if (pl[7:0] == RB_RATE) begin
          legal  = 1'b1;
          rb_val = {10'd0, fft_rate};
        end else if (pl[7:0] == RB_ERR) begin
          legal  = 1'b1;
          rb_val = {4'd0, err_cnt};
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (pl[7:4] == RB_WAV_HI && pl[3:0] == i[3:0]) begin
              legal  = 1'b1;
              rb_val = {10'd0, wav_act[i]};
            end
            if (pl[7:4] == RB_FREQ_HI && pl[3:0] == i[3:0]) begin
              legal  = 1'b1;
              rb_val = PL_W'(freq_act[i]);
            end
          end
        end
      end
      default:   legal = 1'b0;
    endcase
    accept = bus.cmd_valid && legal && !srst_busy;
    reject = bus.cmd_valid && !accept;
  end

  // Handshake pulses, readback response and the saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cmd_ack    <= 1'b0;
      bus.cmd_err    <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      err_cnt        <= '0;
    end else begin
      bus.cmd_ack    <= accept;
      bus.cmd_err    <= reject;
      bus.resp_valid <= accept && (kind == K_READ);
      if (accept && kind == K_READ) bus.resp_data <= rb_val;
      if (reject && err_cnt != ERR_SAT) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Register file: writes land in the shadow copy (and directly in the active
  // copy when staging is off); commit copies every shadow at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sh   <= SEG_DEF;
      rate_sh  <= RATE_DEF;
      seg_en   <= SEG_DEF;
      fft_rate <= RATE_DEF;
      for (int i = 0; i < NUM_CH; i++) begin
        wav_sh[i]   <= '0;
        freq_sh[i]  <= FREQ_RST;
        wav_act[i]  <= '0;
        freq_act[i] <= FREQ_RST;
      end
    end else if (do_srst) begin
      seg_sh   <= SEG_DEF;
      rate_sh  <= RATE_DEF;
      seg_en   <= SEG_DEF;
      fft_rate <= RATE_DEF;
      for (int i = 0; i < NUM_CH; i++) begin
        wav_sh[i]   <= '0;
        freq_sh[i]  <= FREQ_RST;
        wav_act[i]  <= '0;
        freq_act[i] <= FREQ_RST;
      end
    end else if (accept) begin
      case (kind)
        K_SEG: begin
          seg_sh <= pl[2:0];
          if (SHADOW == 0) seg_en <= pl[2:0];
        end
        K_RATE: begin
          rate_sh <= pl[1:0];
          if (SHADOW == 0) fft_rate <= pl[1:0];
        end
        K_WAV: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (pl[11:8] == i[3:0]) begin
              wav_sh[i] <= pl[1:0];
              if (SHADOW == 0) wav_act[i] <= pl[1:0];
            end
          end
        end
        K_FREQ: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (op[3:0] == i[3:0]) begin
              freq_sh[i] <= pl[FREQ_W-1:0];
              if (SHADOW == 0) freq_act[i] <= pl[FREQ_W-1:0];
            end
          end
        end
        K_COMMIT: begin
          if (SHADOW != 0) begin
            seg_en   <= seg_sh;
            fft_rate <= rate_sh;
            for (int i = 0; i < NUM_CH; i++) begin
              wav_act[i]  <= wav_sh[i];
              freq_act[i] <= freq_sh[i];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Flatten per-channel active registers onto the output buses, ch0 in LSBs.
  always_comb begin
    wav_sel = '0;
    freq    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wav_sel[2*i +: 2]       = wav_act[i];
      freq[FREQ_W*i +: FREQ_W] = freq_act[i];
    end
  end

  uart_cmd_pulse #(
    .LEN      (PULSE_LEN),
    .POLARITY (1'b1)
  ) u_refresh (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (do_refresh),
    .clr   (do_srst),
    .pulse (refresh)
  );

  uart_cmd_pulse #(
    .LEN      (RST_LEN),
    .POLARITY (1'b0)
  ) u_soft_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (do_srst),
    .clr   (1'b0),
    .pulse (system_resetn)
  );

endmodule

// File: tb/tb_uart_cmd_regfile.sv
// Scoreboard bench for uart_cmd_regfile: stimulus pushes the reference
// model's expected response, a negedge monitor pops and compares.
module tb_uart_cmd_regfile;
  import uart_cmd_regfile_pkg::*;

  localparam int NUM_CH    = 2;
  localparam int FREQ_W    = 12;
  localparam int FREQ_DEF  = 500;
  localparam int PULSE_LEN = 20000;
  localparam int RST_LEN   = 64;
  localparam int SHADOW    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic refresh, system_resetn;
  logic [2:0] seg_en;
  logic [1:0] fft_rate;
  logic [2*NUM_CH-1:0] wav_sel;
  logic [FREQ_W*NUM_CH-1:0] freq;
  logic [7:0] err_cnt;

  uart_cmd_regfile_if bus();

  uart_cmd_regfile #(
    .NUM_CH(NUM_CH), .FREQ_W(FREQ_W), .FREQ_DEF(FREQ_DEF),
    .PULSE_LEN(PULSE_LEN), .RST_LEN(RST_LEN), .SHADOW(SHADOW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .refresh(refresh), .system_resetn(system_resetn),
    .seg_en(seg_en), .fft_rate(fft_rate), .wav_sel(wav_sel),
    .freq(freq), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [19:0]              cmd;
    logic                     ack;
    logic                     rv;
    logic [11:0]              rd;
    logic [2:0]               seg;
    logic [1:0]               rate;
    logic [2*NUM_CH-1:0]      wav;
    logic [FREQ_W*NUM_CH-1:0] fr;
    logic [7:0]               ec;
  } exp_t;

  exp_t sb_q[$];

  // reference model state (active and shadow), plain integers
  int m_seg, m_rate, m_ec;
  int m_wav[NUM_CH];
  int m_fr[NUM_CH];
  int s_seg, s_rate;
  int s_wav[NUM_CH];
  int s_fr[NUM_CH];
  int srst_edge = -100000;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp, input logic [19:0] cmd);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cmd=%05h got=%0h want=%0h t=%0t", name, cmd, act, exp, $time);
    end
  endtask

  task automatic model_reset_regs();
    m_seg = 0; m_rate = 2; s_seg = 0; s_rate = 2;
    for (int i = 0; i < NUM_CH; i++) begin
      m_wav[i] = 0; s_wav[i] = 0; m_fr[i] = FREQ_DEF; s_fr[i] = FREQ_DEF;
    end
  endtask

  // Apply one command (sampled on clock edge number edge_n) to the model.
  task automatic model_cmd(input logic [19:0] w, input int edge_n, output exp_t e);
    int op, pl, ch, idx, val;
    bit ok, rd;
    op = int'(w[19:12]);
    pl = int'(w[11:0]);
    ok = 0; rd = 0; val = 0;
    if (edge_n > srst_edge && edge_n <= srst_edge + RST_LEN) begin
      ok = 0;
    end else if (op == 'hF0) begin
      ok = (pl % 8) <= 4;
      if (ok) begin if (SHADOW != 0) s_seg = pl % 8; else m_seg = pl % 8; end
    end else if (op == 'hF1) begin
      ok = pl < 4;
      if (ok) begin if (SHADOW != 0) s_rate = pl; else m_rate = pl; end
    end else if (op == 'hF2) begin
      ok = 1;
    end else if (op == 'hF3) begin
      ch = pl / 256;
      ok = ch < NUM_CH;
      if (ok) begin if (SHADOW != 0) s_wav[ch] = pl % 4; else m_wav[ch] = pl % 4; end
    end else if (op == 'hF4) begin
      ok = 1;
      srst_edge = edge_n;
      model_reset_regs();
    end else if (op == 'hF5) begin
      idx = pl % 256;
      rd = 1;
      if (idx == 0) begin ok = 1; val = m_seg; end
      else if (idx == 1) begin ok = 1; val = m_rate; end
      else if (idx == 2) begin ok = 1; val = m_ec; end
      else if (idx >= 16 && idx < 16 + NUM_CH) begin ok = 1; val = m_wav[idx - 16]; end
      else if (idx >= 32 && idx < 32 + NUM_CH) begin ok = 1; val = m_fr[idx - 32]; end
    end else if (op == 'hF6) begin
      ok = 1;
      if (SHADOW != 0) begin
        m_seg = s_seg; m_rate = s_rate;
        for (int i = 0; i < NUM_CH; i++) begin m_wav[i] = s_wav[i]; m_fr[i] = s_fr[i]; end
      end
    end else if (op / 16 == 'hD) begin
      ch = op % 16;
      ok = ch < NUM_CH;
      if (ok) begin
        if (SHADOW != 0) s_fr[ch] = pl % (1 << FREQ_W); else m_fr[ch] = pl % (1 << FREQ_W);
      end
    end
    if (!ok && m_ec < 255) m_ec++;
    e.cmd  = w;
    e.ack  = ok;
    e.rv   = ok && rd;
    e.rd   = 12'(val);
    e.seg  = 3'(m_seg);
    e.rate = 2'(m_rate);
    e.ec   = 8'(m_ec);
    for (int i = 0; i < NUM_CH; i++) begin
      e.wav[2*i +: 2]       = 2'(m_wav[i]);
      e.fr[FREQ_W*i +: FREQ_W] = FREQ_W'(m_fr[i]);
    end
  endtask

  // Present one command for exactly one cycle; call at posedge+1.
  task automatic send(input logic [19:0] w);
    exp_t e;
    model_cmd(w, cyc + 1, e);
    sb_q.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = w;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 20'($urandom);
  endtask

  function automatic logic [19:0] rand_cmd();
    logic [19:0] w;
    logic [7:0] idx;
    int r;
    r = $urandom_range(0, 11);
    case (r)
      0:  w = {8'hF0, 4'($urandom), 5'($urandom), 3'($urandom_range(0, 7))};
      1:  w = {8'hF1, ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 3))};
      2:  w = {8'hF3, 4'($urandom_range(0, 3)), 6'($urandom), 2'($urandom)};
      3, 4: w = {4'hD, 4'($urandom_range(0, 3)), 12'($urandom)};
      5, 6: begin
        case ($urandom_range(0, 7))
          0: idx = 8'h00; 1: idx = 8'h01; 2: idx = 8'h02; 3: idx = 8'h10;
          4: idx = 8'h11; 5: idx = 8'h20; 6: idx = 8'h21; default: idx = 8'($urandom);
        endcase
        w = {8'hF5, 4'($urandom), idx};
      end
      7:  w = {8'hF6, 12'($urandom)};
      8:  w = 20'($urandom);
      9:  w = {8'hF2, 12'($urandom)};
      10: w = ($urandom_range(0, 7) == 0) ? 20'hF4000 : 20'hF6000;
      default: w = {8'($urandom_range(0, 'hCF)), 12'($urandom)};
    endcase
    return w;
  endfunction

  exp_t mon_e;

  // Monitor: every ack/err/resp pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (bus.cmd_ack || bus.cmd_err || bus.resp_valid)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, bus.cmd_ack, bus.cmd_err, bus.resp_valid}, 32'd0, 20'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("cmd_ack", 32'(bus.cmd_ack), 32'(mon_e.ack), mon_e.cmd);
        chk("cmd_err", 32'(bus.cmd_err), 32'(!mon_e.ack), mon_e.cmd);
        chk("resp_valid", 32'(bus.resp_valid), 32'(mon_e.rv), mon_e.cmd);
        if (mon_e.rv) chk("resp_data", 32'(bus.resp_data), 32'(mon_e.rd), mon_e.cmd);
        chk("seg_en", 32'(seg_en), 32'(mon_e.seg), mon_e.cmd);
        chk("fft_rate", 32'(fft_rate), 32'(mon_e.rate), mon_e.cmd);
        chk("wav_sel", 32'(wav_sel), 32'(mon_e.wav), mon_e.cmd);
        chk("freq", 32'(freq), 32'(mon_e.fr), mon_e.cmd);
        chk("err_cnt", 32'(err_cnt), 32'(mon_e.ec), mon_e.cmd);
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0, 20'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg_en"}, 32'(seg_en), 32'd0, 20'd0);
    chk({tag, "_fft_rate"}, 32'(fft_rate), 32'd2, 20'd0);
    chk({tag, "_freq"}, 32'(freq), {8'd0, 12'd500, 12'd500}, 20'd0);
    chk({tag, "_wav_sel"}, 32'(wav_sel), 32'd0, 20'd0);
    chk({tag, "_system_resetn"}, 32'(system_resetn), 32'd1, 20'd0);
    chk({tag, "_refresh"}, 32'(refresh), 32'd0, 20'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0, 20'd0);
    chk({tag, "_handshake"}, {29'd0, bus.cmd_ack, bus.cmd_err, bus.resp_valid}, 32'd0, 20'd0);
    chk({tag, "_resp_data"}, 32'(bus.resp_data), 32'd0, 20'd0);
  endtask

  int hi_cnt, lo_cnt;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    model_reset_regs();
    m_ec = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    // staged writes, then commit
    send(20'hD1123);
    send(20'hF3102);
    send(20'hF6000);
    // rejected commands
    send(20'hF0005);
    send(20'hD2001);
    send(20'h12345);
    // readback of committed freq[1] and of the error count
    send(20'hF5021);
    send(20'hF5002);
    send(20'hF5011);
    drain();

    // refresh with a retrigger 10000 cycles after the first trigger
    chk("refresh_idle", 32'(refresh), 32'd0, 20'hF2000);
    send(20'hF2000);
    fork
      begin
        hi_cnt = 0;
        for (int k = 0; k < 40000; k++) begin
          @(negedge clk);
          if (refresh) hi_cnt++;
          else break;
        end
      end
      begin
        repeat (9999) @(posedge clk);
        #1;
        send(20'hF2000);
      end
    join
    chk("refresh_len", 32'(hi_cnt), 32'd30000, 20'hF2000);
    @(posedge clk); #1;

    // soft reset with a command arriving during the pulse
    send(20'hF0003);
    send(20'hF6000);
    send(20'hF4000);
    fork
      begin
        lo_cnt = 0;
        for (int k = 0; k < 300; k++) begin
          @(negedge clk);
          if (!system_resetn) lo_cnt++;
          else break;
        end
      end
      send(20'hF0001);
    join
    chk("srst_len", 32'(lo_cnt), 32'(RST_LEN), 20'hF4000);
    @(posedge clk); #1;

    // randomized traffic, back-to-back and with gaps
    for (int n = 0; n < 400; n++) begin
      send(rand_cmd());
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();

    // drive the error counter into saturation
    for (int n = 0; n < 270; n++) send({8'($urandom_range(0, 'hCF)), 12'($urandom)});
    send(20'hF5002);
    drain();

    // async reset in the middle of a refresh pulse
    send(20'hF0003);
    send(20'hF6000);
    send(20'hF2000);
    drain();
    repeat (3) @(posedge clk);
    chk("refresh_pre_rst", 32'(refresh), 32'd1, 20'hF2000);
    #3 rst_n = 1'b0;
    #1;
    model_reset_regs();
    m_ec = 0;
    srst_edge = -100000;
    check_reset_outputs("midpulse");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // async reset in the middle of a soft-reset pulse
    send(20'hF4000);
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("srst_active", 32'(system_resetn), 32'd0, 20'hF4000);
    #3 rst_n = 1'b0;
    #1;
    chk("srst_abort", 32'(system_resetn), 32'd1, 20'hF4000);
    chk("sb_final", 32'(sb_q.size()), 32'd0, 20'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
